// File: rtl/garage_door_ctrl_v2.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : garage_door_ctrl_v2
// Description : Single-door motor controller with Activate edge detection,
//               stop/resume, obstruction reversal, travel watchdog and
//               optional auto-close (enabled by defining AUTO_CLOSE_EN).
// Revision    : 2.0
// ============================================================================
module garage_door_ctrl_v2 #(
  parameter int MOVE_TIMEOUT      = 1000,
  parameter int AUTO_CLOSE_CYCLES = 5000,
  parameter int TIMER_W           = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       UP_Max,
  input  logic       DN_Max,
  input  logic       Activate,
  input  logic       Obstruct,
  input  logic       Fault_Clr,
  output logic       UP_M,
  output logic       DN_M,
  output logic [2:0] Door_State,
  output logic       Fault,
  output logic [1:0] Fault_Code
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_UP    = 3'd1,
    S_DOWN  = 3'd2,
    S_STOP  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic [TIMER_W-1:0] c_MOVE_LAST = TIMER_W'(MOVE_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] c_TIMER_MAX = '1;

  generate
    if ((MOVE_TIMEOUT < 1) || (AUTO_CLOSE_CYCLES < 1) ||
        (MOVE_TIMEOUT >= (2 ** TIMER_W)) || (AUTO_CLOSE_CYCLES >= (2 ** TIMER_W))) begin : g_bad_params
      $error("garage_door_ctrl_v2: timer parameters out of range");
    end
  endgenerate

  state_t             r_state;
  logic [TIMER_W-1:0] r_timer;
  logic               r_last_up;
  logic               r_act_q;
  logic [1:0]         r_fault_code;

  state_t             w_next_state;
  logic [1:0]         w_next_code;
  logic [TIMER_W-1:0] w_timer_next;
  logic [TIMER_W-1:0] w_timer_inc;
  logic               w_act_pulse;
  logic               w_conflict;
  logic               w_timeout;
  logic               w_state_change;

  assign w_act_pulse    = Activate & ~r_act_q;
  assign w_conflict     = UP_Max & DN_Max;
  assign w_timeout      = (r_timer == c_MOVE_LAST);
  assign w_state_change = (w_next_state != r_state);
  assign w_timer_inc    = (r_timer == c_TIMER_MAX) ? r_timer : r_timer + 1'b1;

`ifdef AUTO_CLOSE_EN
  localparam logic [TIMER_W-1:0] c_AUTO_LAST = TIMER_W'(AUTO_CLOSE_CYCLES - 1);
  logic w_auto_close;
  assign w_auto_close = UP_Max & ~Obstruct & (r_timer == c_AUTO_LAST);
`endif

  always_comb begin
    w_next_state = r_state;
    w_next_code  = r_fault_code;
    if (w_conflict && (r_state != S_FAULT)) begin
      w_next_state = S_FAULT;
      w_next_code  = 2'b10;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_act_pulse) begin
            w_next_state = UP_Max ? S_DOWN : S_UP;
          end
`ifdef AUTO_CLOSE_EN
          else if (w_auto_close) begin
            w_next_state = S_DOWN;
          end
`endif
        end
        S_UP: begin
          if (UP_Max) begin
            w_next_state = S_IDLE;
          end else if (w_act_pulse) begin
            w_next_state = S_STOP;
          end else if (w_timeout) begin
            w_next_state = S_FAULT;
            w_next_code  = 2'b01;
          end
        end
        S_DOWN: begin
          if (DN_Max) begin
            w_next_state = S_IDLE;
          end else if (Obstruct) begin
            w_next_state = S_UP;
          end else if (w_act_pulse) begin
            w_next_state = S_STOP;
          end else if (w_timeout) begin
            w_next_state = S_FAULT;
            w_next_code  = 2'b01;
          end
        end
        S_STOP: begin
          if (w_act_pulse) begin
            w_next_state = r_last_up ? S_DOWN : S_UP;
          end
        end
        S_FAULT: begin
          if (Fault_Clr && !w_conflict) begin
            w_next_state = S_IDLE;
            w_next_code  = 2'b00;
          end
        end
        default: begin
          w_next_state = S_IDLE;
          w_next_code  = 2'b00;
        end
      endcase
    end
  end

  // Any state change restarts the count, including an obstruction reversal.
  always_comb begin
    w_timer_next = '0;
    if (!w_state_change) begin
      if ((r_state == S_UP) || (r_state == S_DOWN)) begin
        w_timer_next = w_timer_inc;
      end
`ifdef AUTO_CLOSE_EN
      else if ((r_state == S_IDLE) && UP_Max && !Obstruct) begin
        w_timer_next = w_timer_inc;
      end
`endif
    end
  end

  // r_act_q resets high so a button held through reset release is not a press.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_last_up    <= 1'b0;
      r_act_q      <= 1'b1;
      r_fault_code <= 2'b00;
    end else begin
      r_state      <= w_next_state;
      r_timer      <= w_timer_next;
      r_act_q      <= Activate;
      r_fault_code <= w_next_code;
      if (w_state_change && (w_next_state == S_UP)) begin
        r_last_up <= 1'b1;
      end else if (w_state_change && (w_next_state == S_DOWN)) begin
        r_last_up <= 1'b0;
      end
    end
  end

  assign Door_State = r_state;
  assign UP_M       = (r_state == S_UP);
  assign DN_M       = (r_state == S_DOWN);
  assign Fault      = (r_state == S_FAULT);
  assign Fault_Code = r_fault_code;

endmodule
`default_nettype wire

// File: doc/garage_door_ctrl_v2.md
Name: garage_door_ctrl_v2

Overview:
Parametrised successor to the single-door up/down motor controller. Adds:
- Activate edge detection
- stop/resume mid-travel
- obstruction auto-reverse while closing
- travel watchdog with a latched fault and cause code
- optional auto-close timer

Sits between the debounced door sensor/button front-end and the motor driver. Motor outputs are Moore-decoded from the state register.

Parameters:
- MOVE_TIMEOUT, 1000: maximum cycles the motor may run in one direction before a timeout fault.
- AUTO_CLOSE_CYCLES, 5000: cycles the door stays fully open before auto-closing (AUTO_CLOSE_EN only).
- TIMER_W, 16: width of the shared cycle counter. MOVE_TIMEOUT and AUTO_CLOSE_CYCLES must both be < 2^TIMER_W.

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  asynchronous, active-low reset
- UP_Max  in  1  fully-open limit switch
- DN_Max  in  1  fully-closed limit switch
- Activate  in  1  user button, level; acted on at its rising edge
- Obstruct  in  1  beam-break sensor, high = obstructed
- Fault_Clr  in  1  clears a latched fault
- UP_M  out  1  open motor drive
- DN_M  out  1  close motor drive
- Door_State  out  3  0 IDLE, 1 UP, 2 DOWN, 3 STOP, 4 FAULT
- Fault  out  1  high while in FAULT
- Fault_Code  out  2  00 none, 01 timeout, 10 sensor conflict; held until cleared

Behaviour:
- Inputs are synchronous to CLK; no internal synchronisers.
- Reset (async, immediate):
  - state = IDLE; UP_M = DN_M = 0; Fault = 0; Fault_Code = 00; timer = 0.
  - last_dir = DOWN.
  - act_q = 1, so an Activate held through reset release produces no pulse.
- Edge detection: act_pulse = Activate & ~act_q; act_q registers Activate every cycle.
- Outputs: UP_M = (state == UP); DN_M = (state == DOWN); Fault = (state == FAULT). UP_M and DN_M are never high together.
- Latency: an act_pulse present at edge N changes state at edge N, so the motor is driven in the following cycle.
- Sensor conflict: UP_Max & DN_Max in any non-FAULT state -> FAULT with code 10. This has highest priority.
- Transition priority within a state: conflict > limit switch > Obstruct > act_pulse > timeout.
- IDLE:
  - act_pulse & UP_Max -> DOWN.
  - act_pulse & ~UP_Max -> UP (covers closed and mid positions).
- UP:
  - UP_Max -> IDLE.
  - act_pulse -> STOP.
  - Timeout -> FAULT with code 01.
  - Obstruct is ignored.
- DOWN:
  - DN_Max -> IDLE.
  - Obstruct -> UP (reversal; timer restarts).
  - act_pulse -> STOP.
  - Timeout -> FAULT with code 01.
- STOP:
  - Motors off.
  - act_pulse -> direction opposite to last_dir.
  - Obstruct has no effect.
  - No timeout.
- FAULT:
  - Motors off.
  - Fault_Clr & ~(UP_Max & DN_Max) -> IDLE; Fault_Code returns to 00 on exit.
  - Activate is ignored. act_q keeps tracking, so a button held across the clear does not trigger.
- last_dir: updated to UP or DOWN on every entry into UP or DOWN respectively.
- Timer:
  - Cleared on every state change.
  - Increments each cycle in UP or DOWN.
  - The motor runs at most MOVE_TIMEOUT cycles. If no limit switch is seen by the edge on which timer == MOVE_TIMEOUT-1, the state goes to FAULT.
  - A limit switch on that same edge wins.
- Saturation: the timer never wraps. It saturates at 2^TIMER_W-1.

Optional Feature:
Macro: AUTO_CLOSE_EN.
- Defined:
  - In IDLE with UP_Max=1 and Obstruct=0, the timer counts.
  - Reaching AUTO_CLOSE_CYCLES-1 -> DOWN at that edge.
  - Obstruct high or UP_Max low clears the timer.
  - act_pulse still closes immediately.
- Undefined: the timer is idle in IDLE. The door stays open indefinitely, and AUTO_CLOSE_CYCLES is unused.

Test Plan (MOVE_TIMEOUT=8, AUTO_CLOSE_CYCLES=10):
1. Reset with DN_Max=1, then Activate 0->1 -> next cycle UP_M=1 and Door_State=1. Raise UP_Max after 5 cycles -> UP_M=0 and Door_State=0 at that edge.
2. From open (UP_Max=1), pulse Activate -> DN_M=1. Assert Obstruct on the 3rd DOWN cycle -> DN_M=0, UP_M=1 at the next edge, and the timer restarts.
3. From closed, Activate, then with no limit switch -> UP_M high exactly 8 cycles, then Door_State=4, Fault=1, Fault_Code=01. Fault_Clr=1 -> IDLE, Fault_Code=00.
4. While DOWN, pulse Activate -> STOP (DN_M=0). Pulse again -> UP_M=1. Hold Activate high across a Fault_Clr or reset -> no motion.
5. Drive UP_Max=DN_Max=1 in IDLE -> FAULT with code 10. Fault_Clr is ignored until one switch drops. Assert RST mid-UP -> UP_M=0 immediately.
6. With AUTO_CLOSE_EN: door open and idle -> DN_M=1 after 10 cycles. Obstruct pulse at cycle 6 -> the count restarts from 0.
